// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding for the registered bitwise logic pipeline.
// Latency: n/a (types only).  Backpressure: n/a.
package logic_unit_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND    = 3'd0,
      OP_OR     = 3'd1,
      OP_NOT_A  = 3'd2,
      OP_NAND   = 3'd3,
      OP_NOR    = 3'd4,
      OP_XOR    = 3'd5,
      OP_XNOR   = 3'd6,
      OP_PASS_B = 3'd7
   } op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result bus of the logic pipeline: valid/ready on both the operand and result sides.
// Latency: n/a (wires only).  Backpressure: in_ready/out_ready carry the stall.
interface logic_unit_pipe_if
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic [OP_W-1:0]   op;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  y;
   logic              zero;
   logic              parity;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, y, zero, parity
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, y, zero, parity
   );
endinterface

// File: rtl/logic_unit_stage.sv
// One valid/ready register slice carrying an opaque payload.
// Latency: 1 cycle.  Backpressure: accepts when empty or when downstream takes the held beat.
module logic_unit_stage #(
   parameter int PW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          up_vld,
   output logic          up_rdy,
   input  logic [PW-1:0] up_dat,
   output logic          dn_vld,
   input  logic          dn_rdy,
   output logic [PW-1:0] dn_dat
);
   logic          vld_q, vld_d;
   logic [PW-1:0] dat_q, dat_d;

   // An empty slot always accepts, so bubbles collapse under a downstream stall.
   assign up_rdy = !vld_q || dn_rdy;

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (up_rdy) begin
         vld_d = up_vld;
      end
      if (up_vld && up_rdy) begin
         dat_d = up_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign dn_vld = vld_q;
   assign dn_dat = dat_q;
endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit (8 functions) with zero/parity flags, followed by STAGES register slices.
// Latency: STAGES cycles.  Backpressure: full valid/ready, in_ready drops only when every stage is occupied.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   logic_unit_pipe_if.slave bus
);
   localparam int PW = WIDTH + 2;

   typedef struct packed {
      logic [WIDTH-1:0] y;
      logic             zero;
      logic             parity;
   } res_t;

   function automatic logic [WIDTH-1:0] logic_eval(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input op_e              op
   );
      logic [WIDTH-1:0] r;
      r = b;
      case (op)
         OP_AND:    r = a & b;
         OP_OR:     r = a | b;
         OP_NOT_A:  r = ~a;
         OP_NAND:   r = ~(a & b);
         OP_NOR:    r = ~(a | b);
         OP_XOR:    r = a ^ b;
         OP_XNOR:   r = ~(a ^ b);
         OP_PASS_B: r = b;
         default:   r = b;
      endcase
      return r;
   endfunction

   res_t res_in;

   // Flags are derived once here and then travel as plain payload.
   always_comb begin
      res_in        = '0;
      res_in.y      = logic_eval(bus.a, bus.b, op_e'(bus.op));
      res_in.zero   = ~|res_in.y;
      res_in.parity = ^res_in.y;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      logic vld_in, rdy_out, vld, rdy_in;
      res_t dat_in, dat;

      if (k == 0) begin : g_head
         assign vld_in = bus.in_valid;
         assign dat_in = res_in;
      end else begin : g_mid
         assign vld_in = g_stg[k-1].vld;
         assign dat_in = g_stg[k-1].dat;
      end

      if (k == STAGES - 1) begin : g_tail
         assign rdy_in = bus.out_ready;
      end else begin : g_link
         assign rdy_in = g_stg[k+1].rdy_out;
      end

      logic_unit_stage #(.PW(PW)) u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .up_vld (vld_in),
         .up_rdy (rdy_out),
         .up_dat (dat_in),
         .dn_vld (vld),
         .dn_rdy (rdy_in),
         .dn_dat (dat)
      );
   end

   res_t res_out;

   assign res_out       = g_stg[STAGES-1].dat;
   assign bus.in_ready  = g_stg[0].rdy_out;
   assign bus.out_valid = g_stg[STAGES-1].vld;
   assign bus.y         = res_out.y;
   assign bus.zero      = res_out.zero;
   assign bus.parity    = res_out.parity;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: an 8-bit/2-stage and a 32-bit/4-stage instance checked against a queue model.
module tb_logic_unit_pipe;
   import logic_unit_pkg::*;

   typedef struct {
      int unsigned c;
      logic [63:0] y;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        iv [2];
   logic [63:0] ia [2];
   logic [63:0] ib [2];
   logic [2:0]  iop [2];
   logic        ordy [2];
   logic        ir [2];
   logic        ov [2];
   logic        zf [2];
   logic        pf [2];
   logic [63:0] yv [2];

   logic_unit_pipe_if #(.WIDTH(8))  bus0 ();
   logic_unit_pipe_if #(.WIDTH(32)) bus1 ();

   assign bus0.in_valid  = iv[0];
   assign bus0.a         = ia[0][7:0];
   assign bus0.b         = ib[0][7:0];
   assign bus0.op        = iop[0];
   assign bus0.out_ready = ordy[0];
   assign ir[0]          = bus0.in_ready;
   assign ov[0]          = bus0.out_valid;
   assign yv[0]          = 64'(bus0.y);
   assign zf[0]          = bus0.zero;
   assign pf[0]          = bus0.parity;

   assign bus1.in_valid  = iv[1];
   assign bus1.a         = ia[1][31:0];
   assign bus1.b         = ib[1][31:0];
   assign bus1.op        = iop[1];
   assign bus1.out_ready = ordy[1];
   assign ir[1]          = bus1.in_ready;
   assign ov[1]          = bus1.out_valid;
   assign yv[1]          = 64'(bus1.y);
   assign zf[1]          = bus1.zero;
   assign pf[1]          = bus1.parity;

   logic_unit_pipe #(.WIDTH(8), .STAGES(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   logic_unit_pipe #(.WIDTH(32), .STAGES(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   int checks = 0;
   int failures = 0;
   int unsigned cyc = 0;
   logic lat_on = 1'b0;

   exp_t q0[$];
   exp_t q1[$];
   int acc_cnt [2] = '{0, 0};
   int out_cnt [2] = '{0, 0};
   logic hold_act [2] = '{1'b0, 1'b0};
   logic [63:0] hold_y [2];
   logic [63:0] last_y [2];
   logic last_z [2];
   logic last_p [2];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int stg(input int d);
      return (d != 0) ? 4 : 2;
   endfunction

   // Reference: the opcode table evaluated on 64-bit values, then cut to the instance width.
   function automatic logic [63:0] ref_y(input int d, input logic [63:0] a, input logic [63:0] b,
                                         input logic [2:0] op);
      logic [63:0] r;
      logic [63:0] m;
      m = (d != 0) ? 64'hFFFF_FFFF : 64'hFF;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = ~a;
         3'd3: r = ~(a & b);
         3'd4: r = ~(a | b);
         3'd5: r = a ^ b;
         3'd6: r = ~(a ^ b);
         default: r = b;
      endcase
      return r & m;
   endfunction

   function automatic int qsize(input int d);
      return (d != 0) ? q1.size() : q0.size();
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   task automatic mon_one(input int d);
      exp_t e;
      if (hold_act[d]) begin
         check_eq("hold_valid", 64'(ov[d]), 64'd1);
         check_eq("hold_y", yv[d], hold_y[d]);
      end
      hold_act[d] = ov[d] && !ordy[d];
      hold_y[d]   = yv[d];
      if (ov[d] && ordy[d]) begin
         check_eq("out_has_expected", 64'(qsize(d) > 0), 64'd1);
         if (qsize(d) > 0) begin
            if (d != 0) e = q1.pop_front();
            else        e = q0.pop_front();
            check_eq("y", yv[d], e.y);
            check_eq("zero", 64'(zf[d]), 64'(e.y == 64'd0));
            check_eq("parity", 64'(pf[d]), 64'($countones(e.y) % 2));
            if (lat_on) check_eq("latency", 64'(cyc - e.c), 64'(stg(d)));
         end
         last_y[d] = yv[d];
         last_z[d] = zf[d];
         last_p[d] = pf[d];
         out_cnt[d]++;
      end
      if (iv[d] && ir[d]) begin
         e.c = cyc;
         e.y = ref_y(d, ia[d], ib[d], iop[d]);
         if (d != 0) q1.push_back(e);
         else        q0.push_back(e);
         acc_cnt[d]++;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) mon_one(d);
      end else begin
         q0.delete();
         q1.delete();
         hold_act[0] = 1'b0;
         hold_act[1] = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_beat(input int d);
      ia[d]  = {$urandom, $urandom};
      ib[d]  = {$urandom, $urandom};
      iop[d] = 3'($urandom_range(0, 7));
   endtask

   task automatic send_one(input int d, input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
      int n0;
      int k;
      n0 = acc_cnt[d];
      k = 0;
      iv[d] = 1'b1; ia[d] = a; ib[d] = b; iop[d] = op;
      while (acc_cnt[d] == n0 && k < 20) begin
         step();
         k++;
      end
      iv[d] = 1'b0;
      check_eq("accept", 64'(acc_cnt[d] != n0), 64'd1);
   endtask

   task automatic wait_out(input int d, input int target, input int budget);
      int k;
      k = 0;
      while (out_cnt[d] < target && k < budget) begin
         step();
         k++;
      end
      check_eq("wait_out", 64'(out_cnt[d] >= target), 64'd1);
   endtask

   task automatic drain(input int d);
      int k;
      k = 0;
      iv[d] = 1'b0;
      ordy[d] = 1'b1;
      while (qsize(d) > 0 && k < 40) begin
         step();
         k++;
      end
      step();
      check_eq("drain_empty", 64'(qsize(d)), 64'd0);
   endtask

   task automatic check_reset_state(input string tag);
      for (int d = 0; d < 2; d++) begin
         check_eq({tag, "_out_valid"}, 64'(ov[d]), 64'd0);
         check_eq({tag, "_y"}, yv[d], 64'd0);
         check_eq({tag, "_zero"}, 64'(zf[d]), 64'd0);
         check_eq({tag, "_parity"}, 64'(pf[d]), 64'd0);
         check_eq({tag, "_in_ready"}, 64'(ir[d]), 64'd1);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] tbl [8];
      int n0;
      tbl = '{64'h30, 64'hFC, 64'h0F, 64'hCF, 64'h03, 64'hCC, 64'h33, 64'h3C};
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b0; ia[d] = '0; ib[d] = '0; iop[d] = '0; ordy[d] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      #2 rst_n = 1'b1;
      step();
      check_reset_state("post_reset");

      // Single beats through each opcode, then the zero-flag cases.
      lat_on = 1'b1;
      for (int d = 0; d < 2; d++) begin
         for (int op = 0; op < 8; op++) begin
            n0 = out_cnt[d];
            send_one(d, 64'hF0, 64'h3C, 3'(op));
            wait_out(d, n0 + 1, 10);
            if (d == 0) begin
               check_eq("t1_y", last_y[0], tbl[op]);
               check_eq("t1_zero", 64'(last_z[0]), 64'd0);
               check_eq("t1_parity", 64'(last_p[0]), 64'd0);
            end
         end
      end
      n0 = out_cnt[0];
      send_one(0, 64'hAA, 64'h55, 3'(OP_AND));
      wait_out(0, n0 + 1, 10);
      check_eq("and_y", last_y[0], 64'h00);
      check_eq("and_zero", 64'(last_z[0]), 64'd1);
      check_eq("and_parity", 64'(last_p[0]), 64'd0);
      send_one(0, 64'hAA, 64'h55, 3'(OP_XOR));
      wait_out(0, n0 + 2, 10);
      check_eq("xor_y", last_y[0], 64'hFF);
      check_eq("xor_zero", 64'(last_z[0]), 64'd0);
      check_eq("xor_parity", 64'(last_p[0]), 64'd0);

      // Back-to-back: 16 beats, latency checks force consecutive outputs.
      for (int d = 0; d < 2; d++) begin
         n0 = out_cnt[d];
         for (int i = 0; i < 16; i++) begin
            iv[d] = 1'b1;
            rand_beat(d);
            @(negedge clk);
            check_eq("b2b_in_ready", 64'(ir[d]), 64'd1);
            step();
         end
         iv[d] = 1'b0;
         wait_out(d, n0 + 16, 20);
      end

      // Backpressure from empty, then a simultaneous drain/accept while full.
      lat_on = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n0 = acc_cnt[d];
         ordy[d] = 1'b0;
         iv[d] = 1'b1;
         rand_beat(d);
         repeat (5) begin
            step();
            rand_beat(d);
         end
         check_eq("bp_accepts", 64'(acc_cnt[d] - n0), 64'(stg(d)));
         @(negedge clk);
         check_eq("bp_in_ready", 64'(ir[d]), 64'd0);
         step();
         check_eq("full_occupancy", 64'(qsize(d)), 64'(stg(d)));
         ordy[d] = 1'b1;
         @(negedge clk);
         check_eq("simul_in_ready", 64'(ir[d]), 64'd1);
         step();
         check_eq("simul_occupancy", 64'(qsize(d)), 64'(stg(d)));
         iv[d] = 1'b0;
         ordy[d] = 1'b0;
         @(negedge clk);
         check_eq("simul_out_valid", 64'(ov[d]), 64'd1);
         drain(d);
      end

      // Random valid/ready traffic against the scoreboard.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 300; i++) begin
            iv[d] = ($urandom_range(0, 9) < 7);
            ordy[d] = ($urandom_range(0, 9) < 6);
            rand_beat(d);
            step();
         end
         drain(d);
      end

      // Asynchronous reset with two beats in flight.
      for (int d = 0; d < 2; d++) begin
         ordy[d] = 1'b0;
         iv[d] = 1'b1;
         rand_beat(d);
         step();
         rand_beat(d);
         step();
         iv[d] = 1'b0;
         repeat (stg(d)) step();
         check_eq("pre_reset_valid", 64'(ov[d]), 64'd1);
         #2 rst_n = 1'b0;
         #1;
         check_eq("async_out_valid", 64'(ov[d]), 64'd0);
         check_eq("async_y", yv[d], 64'd0);
         check_eq("async_in_ready", 64'(ir[d]), 64'd1);
         step();
         #2 rst_n = 1'b1;
         ordy[d] = 1'b1;
         repeat (6) begin
            @(negedge clk);
            check_eq("no_stale", 64'(ov[d]), 64'd0);
         end
         step();
         lat_on = 1'b1;
         n0 = out_cnt[d];
         send_one(d, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 3'(OP_XOR));
         wait_out(d, n0 + 1, 10);
         lat_on = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, registered successor to the two-input combinational gate block. It takes a WIDTH-bit operand pair and a 3-bit opcode that selects one of eight bitwise functions. The result, a zero flag and a parity flag travel through a STAGES-deep valid/ready pipeline with full backpressure. It sits between operand producers and any consumer that may stall, such as a result FIFO or bus master.

Parameters:
WIDTH, 8, operand and result width in bits (1..64)
STAGES, 2, pipeline depth in register stages (1..4); this is the latency in cycles

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat present
in_ready  output  1  block can accept the beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  function select, encoding in package
out_valid  output  1  result beat present
out_ready  input  1  consumer accepts the result this cycle
y  output  WIDTH  result
zero  output  1  y == 0
parity  output  1  XOR-reduction of y

Behaviour:
- Reset:
  - rst_n low clears every stage valid bit, data and flags at once, with no clock needed.
  - After reset: out_valid=0, y=0, zero=0, parity=0, in_ready=1.
  - Reset takes effect mid-operation; in-flight beats are dropped, never emitted.
- Opcodes (op value, function, result y):
  - 0 AND, y = a&b
  - 1 OR, y = a|b
  - 2 NOT_A, y = ~a (b is ignored)
  - 3 NAND, y = ~(a&b)
  - 4 NOR, y = ~(a|b)
  - 5 XOR, y = a^b
  - 6 XNOR, y = ~(a^b)
  - 7 PASS_B, y = b
  - All functions are bitwise over WIDTH bits; there is no carry and no width growth.
- Computation placement:
  - The function is evaluated combinationally at the input and captured into stage 0.
  - zero and parity are computed from the computed y before stage 0 and carried alongside it.
  - Later stages are pure registers.
- Handshake:
  - A transfer happens on a rising edge when valid && ready are both high on that interface.
  - Stage k holds (valid_k, y_k, zero_k, parity_k).
  - ready_k = !valid_k || ready_{k+1}, with ready_STAGES = out_ready.
  - in_ready = ready_0.
  - Bubbles collapse: a stage that is empty always accepts, even when downstream is stalled.
- Latency and throughput:
  - An unstalled beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, so it is valid for the cycle following edge N+STAGES-1.
  - Throughput is 1 beat/cycle when out_ready is held high.
- Stall:
  - While out_valid && !out_ready, the outputs y, zero, parity and out_valid hold stable.
  - The pipe fills upstream; in_ready drops only when all STAGES stages are valid.
- Simultaneous events: when the pipe is full and out_ready is high in the same cycle, the output drains and a new input is accepted on the same edge. No beat is lost or duplicated.
- Ordering: beats leave strictly in acceptance order.
- Input rules: inputs are sampled only at a transfer. a, b and op may change freely when in_valid=0.
- Registered outputs: y and the flags are registered.
- in_ready path: in_ready is combinational from out_ready through the ready chain. This is accepted at depth ≤ 4.

Decomposition:
- Package logic_unit_pkg:
  - op_e enum with the 8 opcodes above
  - OP_W = 3
  - function logic_eval(a, b, op), parameterised by WIDTH via a parameterised class or inline function in the module
- Sub-module logic_unit_stage: one register stage with its valid/ready slice, parameterised by payload width (WIDTH+2). The top instantiates STAGES copies in a generate loop.

Test Plan:
1. Reset and single beats: reset, then WIDTH=8, STAGES=2, out_ready=1; send a=8'hF0, b=8'h3C for each op 0..7 -> y = 30, FC, 0F, CF, 03, CC, 33, 3C respectively. Each arrives 2 cycles after acceptance, with zero=0 and parity matching popcount (e.g. y=8'h30 gives parity=0).
2. Zero flag: a=8'hAA, b=8'h55, op=AND -> y=0, zero=1, parity=0. Same operands with op=XOR -> y=FF, zero=0, parity=0.
3. Back-to-back: 16 consecutive beats with out_ready=1 -> 16 results on consecutive cycles, in order, in_ready held at 1.
4. Backpressure: drop out_ready for 5 cycles with the stream running -> in_ready falls after STAGES extra accepts and y holds stable. Raise out_ready -> all beats drain in order with no loss or duplication; a random out_ready pattern is checked against a scoreboard.
5. Full plus simultaneous: pipe full, out_ready=1 and in_valid=1 on the same edge -> one output drained, one input accepted, occupancy unchanged.
6. Reset mid-stream: assert rst_n=0 asynchronously with 2 beats in flight -> out_valid drops immediately, without waiting for a clock edge. After release, no stale beat appears and the first new beat emerges with latency STAGES. Repeat with WIDTH=32, STAGES=4.
